// File: rtl/frame_pkg.sv
// Shared types and constants for the frame reader block.
package frame_pkg;

   localparam int ADDR_W          = 20;
   localparam int NUM_PIX_DEFAULT = 307200;

   typedef enum logic [1:0] {
      IDLE,
      READING,
      DRAINING
   } fr_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous output buffer with occupancy count; the head entry is presented combinationally.
module pix_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Data is forced to zero while empty so the consumer never sees stale contents.
   assign valid   = (count != '0);
   assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/frame_reader.sv
// Streams one frame of pixels from a fixed-latency RAM into a ready/valid consumer.
// Optional FRAME_READER_LAST_EN adds a pix_last end-of-frame marker.
module frame_reader
   import frame_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int NUM_PIX      = NUM_PIX_DEFAULT,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              beginRead,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_read,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              complete,
   output logic              busy
`ifdef FRAME_READER_LAST_EN
   ,output logic             pix_last
`endif
);

   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

   fr_state_t               state_q;
   fr_state_t               state_d;
   logic                    begin_d;
   logic                    start_edge;
   logic [ADDR_W-1:0]       addr_q;
   logic [ADDR_W-1:0]       xfer_q;
   logic [READ_LATENCY-1:0] lat_pipe;
   logic [CNT_W-1:0]        in_flight;
   logic [CNT_W-1:0]        fifo_count;
   logic                    issue_ok;
   logic                    transfer;

   assign start_edge = beginRead & ~begin_d;
   assign transfer   = pix_valid & pix_ready;
   assign complete   = (state_q == IDLE);
   assign busy       = ~complete;
   assign ram_addr   = addr_q;

   // Credits: every slot is either occupied or reserved by a read still in the RAM pipe.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         in_flight = in_flight + CNT_W'(lat_pipe[i]);
      end
      issue_ok = ({1'b0, fifo_count} + {1'b0, in_flight}) < (CNT_W + 1)'(FIFO_DEPTH);
   end

   always_comb begin
      state_d  = state_q;
      ram_read = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d = READING;
            end
         end
         READING: begin
            if (issue_ok) begin
               ram_read = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = DRAINING;
               end
            end
         end
         DRAINING: begin
            if (transfer && (xfer_q == LAST_ADDR)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Clearing lat_pipe on reset is what discards reads already launched into the RAM.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         begin_d  <= 1'b0;
         addr_q   <= '0;
         xfer_q   <= '0;
         lat_pipe <= '0;
      end else begin
         begin_d  <= beginRead;
         lat_pipe <= (lat_pipe << 1) | READ_LATENCY'(ram_read);
         if ((state_q == IDLE) && start_edge) begin
            addr_q <= '0;
            xfer_q <= '0;
         end else begin
            if (ram_read && (addr_q != LAST_ADDR)) begin
               addr_q <= addr_q + ADDR_W'(1);
            end
            if (transfer && (xfer_q != LAST_ADDR)) begin
               xfer_q <= xfer_q + ADDR_W'(1);
            end
         end
      end
   end

   pix_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr_en   (lat_pipe[READ_LATENCY-1]),
      .wr_data (ram_data),
      .rd_en   (transfer),
      .rd_data (pix_data),
      .valid   (pix_valid),
      .count   (fifo_count)
   );

`ifdef FRAME_READER_LAST_EN
   assign pix_last = pix_valid && (state_q == DRAINING) && (xfer_q == LAST_ADDR);
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Randomized bench for frame_reader against a pixel-stream reference model.
// Define FRAME_READER_LAST_EN to also check pix_last.
module tb_frame_reader;

   localparam int TB_DATA_W  = 16;
   localparam int TB_NUM_PIX = 16;
   localparam int TB_LAT     = 2;
   localparam int TB_DEPTH   = 4;

   logic                 Clk = 1'b0;
   logic                 Reset;
   logic                 beginRead;
   logic [19:0]          ram_addr;
   logic                 ram_read;
   logic [TB_DATA_W-1:0] ram_data;
   logic [TB_DATA_W-1:0] pix_data;
   logic                 pix_valid;
   logic                 pix_ready;
   logic                 complete;
   logic                 busy;
`ifdef FRAME_READER_LAST_EN
   logic                 pix_last;
`endif

   int comp_count = 0;
   int mism_count = 0;
   int ready_mode = 1;

   bit in_frame       = 1'b0;
   int exp_idx        = 0;
   int issue_idx      = 0;
   bit prev_begin     = 1'b0;
   bit hold_pending   = 1'b0;
   bit check_complete = 1'b0;

   always #5 Clk = ~Clk;

   frame_reader #(
      .DATA_W       (TB_DATA_W),
      .NUM_PIX      (TB_NUM_PIX),
      .READ_LATENCY (TB_LAT),
      .FIFO_DEPTH   (TB_DEPTH)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .beginRead (beginRead),
      .ram_addr  (ram_addr),
      .ram_read  (ram_read),
      .ram_data  (ram_data),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .complete  (complete),
      .busy      (busy)
`ifdef FRAME_READER_LAST_EN
      ,.pix_last (pix_last)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      comp_count++;
      if (observed !== expected) begin
         mism_count++;
         $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge Clk);
      #1 beginRead = 1'b1;
      @(posedge Clk);
      #1 beginRead = 1'b0;
   endtask

   task automatic waitFrameEnd(input int budget);
      int n;
      n = 0;
      while (in_frame && (n < budget)) begin
         @(negedge Clk);
         n++;
      end
      checkOutput("frame_done", 32'(in_frame), 32'(0));
      repeat (3) @(negedge Clk);
   endtask

   task automatic waitPixel(input int idx);
      int n;
      n = 0;
      while ((exp_idx < idx) && (n < 1000)) begin
         @(negedge Clk);
         n++;
      end
      checkOutput("reach_pixel", 32'(exp_idx >= idx), 32'(1));
   endtask

   // Consumer handshake: held low, held high, or a fair coin each cycle.
   initial begin
      pix_ready = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         case (ready_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // RAM returns data = address exactly TB_LAT cycles after the strobe, noise otherwise.
   initial begin
      bit        rq_v [TB_LAT];
      logic [19:0] rq_a [TB_LAT];
      for (int i = 0; i < TB_LAT; i++) begin
         rq_v[i] = 1'b0;
         rq_a[i] = '0;
      end
      ram_data = '0;
      forever begin
         @(posedge Clk);
         for (int i = TB_LAT - 1; i > 0; i--) begin
            rq_v[i] = rq_v[i-1];
            rq_a[i] = rq_a[i-1];
         end
         rq_v[0] = ram_read;
         rq_a[0] = ram_addr;
         #1 ram_data = rq_v[TB_LAT-1] ? rq_a[TB_LAT-1][15:0] : 16'($urandom);
      end
   end

   // Reference model: a frame is 0..NUM_PIX-1 issued and delivered in order, with at most
   // TB_DEPTH pixels requested but not yet consumed.
   always @(negedge Clk) begin
      if (Reset) begin
         in_frame       = 1'b0;
         exp_idx        = 0;
         issue_idx      = 0;
         prev_begin     = 1'b0;
         hold_pending   = 1'b0;
         check_complete = 1'b0;
      end else begin
         if (check_complete) begin
            checkOutput("complete_after_last", 32'(complete), 32'(1));
            checkOutput("busy_after_last", 32'(busy), 32'(0));
            check_complete = 1'b0;
         end
         if (beginRead && !prev_begin && !in_frame) begin
            in_frame  = 1'b1;
            exp_idx   = 0;
            issue_idx = 0;
         end
         prev_begin = beginRead;
         if (!in_frame) begin
            checkOutput("idle_valid", 32'(pix_valid), 32'(0));
            checkOutput("idle_read", 32'(ram_read), 32'(0));
         end else begin
            if (hold_pending) begin
               checkOutput("valid_hold", 32'(pix_valid), 32'(1));
            end
            if (ram_read) begin
               checkOutput("read_addr", 32'(ram_addr), 32'(issue_idx));
               checkOutput("credit", 32'((issue_idx - exp_idx) < TB_DEPTH), 32'(1));
               issue_idx++;
            end
`ifdef FRAME_READER_LAST_EN
            if (pix_valid) begin
               checkOutput("pix_last", 32'(pix_last), 32'(exp_idx == TB_NUM_PIX - 1));
            end else begin
               checkOutput("pix_last_idle", 32'(pix_last), 32'(0));
            end
`endif
            if (pix_valid && pix_ready) begin
               checkOutput("pix_data", 32'(pix_data), 32'(exp_idx[15:0]));
               exp_idx++;
               if (exp_idx == TB_NUM_PIX) begin
                  checkOutput("complete_at_last", 32'(complete), 32'(0));
                  in_frame       = 1'b0;
                  check_complete = 1'b1;
               end
            end
            hold_pending = pix_valid && !pix_ready;
         end
      end
   end

   initial begin
      int n;
      Reset      = 1'b0;
      beginRead  = 1'b0;
      ready_mode = 1;
      #2 Reset = 1'b1;
      repeat (3) @(negedge Clk);
      checkOutput("rst_complete", 32'(complete), 32'(1));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_read", 32'(ram_read), 32'(0));
      checkOutput("rst_valid", 32'(pix_valid), 32'(0));
      checkOutput("rst_data", 32'(pix_data), 32'(0));
      checkOutput("rst_addr", 32'(ram_addr), 32'(0));
      @(posedge Clk);
      #1 Reset = 1'b0;
      repeat (10) @(negedge Clk);
      checkOutput("idle10_complete", 32'(complete), 32'(1));
      checkOutput("idle10_read", 32'(ram_read), 32'(0));
      checkOutput("idle10_valid", 32'(pix_valid), 32'(0));

      // Full-rate frame: first strobe one cycle after the edge is sampled.
      applyStimulus();
      checkOutput("first_read", 32'(ram_read), 32'(1));
      checkOutput("first_addr", 32'(ram_addr), 32'(0));
      waitFrameEnd(2000);

      // Consumer stalled: only TB_DEPTH reads may be launched.
      ready_mode = 0;
      repeat (2) @(posedge Clk);
      applyStimulus();
      n = 0;
      repeat (20) begin
         @(negedge Clk);
         if (ram_read) n++;
      end
      checkOutput("stall_reads", 32'(n), 32'(TB_DEPTH));
      checkOutput("stall_valid", 32'(pix_valid), 32'(1));
      ready_mode = 1;
      waitFrameEnd(2000);

      ready_mode = 2;
      repeat (3) begin
         applyStimulus();
         waitFrameEnd(2000);
         repeat ($urandom_range(0, 4)) @(negedge Clk);
      end

      // A second edge mid-frame must not restart or extend the frame.
      applyStimulus();
      waitPixel(5);
      applyStimulus();
      waitFrameEnd(2000);
      repeat (5) @(negedge Clk);
      checkOutput("no_restart", 32'(complete), 32'(1));

      // Reset mid-frame: outstanding RAM returns must never surface.
      ready_mode = 1;
      applyStimulus();
      waitPixel(8);
      @(posedge Clk);
      #1 Reset = 1'b1;
      @(negedge Clk);
      checkOutput("midrst_complete", 32'(complete), 32'(1));
      checkOutput("midrst_busy", 32'(busy), 32'(0));
      checkOutput("midrst_valid", 32'(pix_valid), 32'(0));
      checkOutput("midrst_read", 32'(ram_read), 32'(0));
      @(posedge Clk);
      #1 Reset = 1'b0;
      n = 0;
      repeat (8) begin
         @(negedge Clk);
         if (pix_valid) n++;
      end
      checkOutput("late_data_dropped", 32'(n), 32'(0));

      ready_mode = 2;
      applyStimulus();
      waitFrameEnd(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_count, mism_count);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
